// File: rtl/reg_arbiter_pkg.sv
// Shared widths, state encoding and default lock timeout for the register-file arbiter.
package reg_arb_pkg;

  localparam int ADDR_W           = 6;
  localparam int DATA_W           = 8;
  localparam int LOCK_TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// Round-robin picker: first requesting index at or above ptr, wrapping to 0; one-hot result.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Multi-requester arbiter in front of a single-port register file, with ownership locking.
// Optional forced lock release on an idle owner is built when REG_ARB_LOCK_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | round-robin arbitration among all requesters
// LOCKED | only owner_q may be granted
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rf_address,
  output logic                      rf_write_en,
  output logic [DATA_W-1:0]         rf_wr_data,
  output logic                      rf_read_en,
  input  logic [DATA_W-1:0]         rf_rd_data,
  output logic                      lock_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("reg_arbiter: NUM_REQ must be 2..8");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255) begin : g_bad_lock_timeout
    $error("reg_arbiter: LOCK_TIMEOUT must be 1..255");
  end

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   rf_address_q, rf_address_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                rf_write_en_q, rf_write_en_d;
  logic                rf_read_en_q, rf_read_en_d;

  logic [NUM_REQ-1:0]  rr_gnt, owner_oh;
  logic [PTR_W-1:0]    sel_idx, sel_inc, owner_inc;
  logic                xfer, sel_we, sel_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                to_fire;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    gnt  = (state_q == LOCKED) ? (req & owner_oh) : rr_gnt;
    xfer = |gnt;

    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_idx   = PTR_W'(i);
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end

    sel_inc   = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  end

`ifdef REG_ARB_LOCK_TIMEOUT_EN
  // Down-counter reloaded on lock entry and every owner transfer; terminal count at zero.
  localparam logic [7:0] TMR_LOAD = 8'(LOCK_TIMEOUT - 1);

  logic [7:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d   = tmr_q;
    to_fire = 1'b0;
    if (state_q == LOCKED) begin
      if (xfer) begin
        tmr_d = TMR_LOAD;
      end else if (tmr_q == 8'd0) begin
        to_fire = 1'b1;
      end else begin
        tmr_d = tmr_q - 8'd1;
      end
    end else if (xfer && sel_lock) begin
      tmr_d = TMR_LOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  assign lock_timeout = to_fire;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    rf_write_en_d = 1'b0;
    rf_read_en_d  = 1'b0;
    rf_address_d  = '0;
    rf_wr_data_d  = '0;
    rd_pend_d     = '0;
    rsp_valid_d   = rd_pend_q;

    if (xfer) begin
      rr_ptr_d      = sel_inc;
      rf_address_d  = sel_addr;
      rf_write_en_d = sel_we;
      rf_read_en_d  = !sel_we;
      rf_wr_data_d  = sel_we ? sel_wdata : '0;
      rd_pend_d     = sel_we ? '0 : gnt;
    end

    case (state_q)
      IDLE: begin
        if (xfer && sel_lock) begin
          state_d = LOCKED;
          owner_d = sel_idx;
        end
      end
      LOCKED: begin
        if (xfer && !sel_lock) begin
          state_d = IDLE;
        end else if (to_fire) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing rd_pend_q/rsp_valid_q here drops any read still in the pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      rd_pend_q     <= '0;
      rsp_valid_q   <= '0;
      rf_address_q  <= '0;
      rf_wr_data_q  <= '0;
      rf_write_en_q <= 1'b0;
      rf_read_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      rd_pend_q     <= rd_pend_d;
      rsp_valid_q   <= rsp_valid_d;
      rf_address_q  <= rf_address_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_write_en_q <= rf_write_en_d;
      rf_read_en_q  <= rf_read_en_d;
    end
  end

  assign rf_address  = rf_address_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_write_en = rf_write_en_q;
  assign rf_read_en  = rf_read_en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = (|rsp_valid_q) ? rf_rd_data : '0;

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: directed vector table, lock/reset sequences, random run vs model.
module tb_reg_arbiter;

  localparam int N  = 3;
  localparam int LT = 4;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [17:0] AD_A = {6'h0C, 6'h0C, 6'h05};
  localparam logic [17:0] AD_B = {6'h0E, 6'h0C, 6'h05};
  localparam logic [23:0] W0   = 24'h0;
  localparam logic [23:0] W1   = {8'h00, 8'hA5, 8'h00};
  localparam logic [23:0] W2   = {8'h77, 8'hA5, 8'h00};
  localparam logic [23:0] W3   = {8'h78, 8'hA5, 8'h00};

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, req_we, req_lock;
  logic [17:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, rf_wr_data, rf_rd_data;
  logic [5:0]  rf_address;
  logic        rf_write_en, rf_read_en, lock_timeout;

  always #5 clock = ~clock;

  reg_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rf_address   (rf_address),
    .rf_write_en  (rf_write_en),
    .rf_wr_data   (rf_wr_data),
    .rf_read_en   (rf_read_en),
    .rf_rd_data   (rf_rd_data),
    .lock_timeout (lock_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: arbitration state as plain integers, register file as an array.
  bit         m_locked;
  int         m_owner, m_ptr, m_idle, m_g;
  bit         m_lto;
  logic       e_we, e_re;
  logic [5:0] e_addr;
  logic [7:0] e_wd, e_rdata, p_rdata;
  logic [2:0] e_rsp, p_rsp;
  logic [7:0] ref_mem [64];
  logic [7:0] rf_mem  [64];
  logic       s_we, s_re;
  logic [5:0] s_addr;
  logic [7:0] s_wd;

  function automatic int m_pick(input logic [2:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_idle = 0; m_g = -1; m_lto = 1'b0;
    e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wd = '0; e_rdata = '0; e_rsp = '0;
    p_rsp = '0; p_rdata = '0;
  endtask

  task automatic drive_and_check(input logic [2:0] r, input logic [2:0] we, input logic [2:0] lk,
                                 input logic [17:0] a, input logic [23:0] d);
    @(negedge clock);
    req = r; req_we = we; req_lock = lk; req_addr = a; req_wdata = d;
    #1;
    m_g   = m_pick(r);
    m_lto = m_locked && (m_g < 0) && TO_EN && (m_idle + 1 == LT);
    chk("gnt", 32'(gnt), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
    chk("rf_write_en", 32'(rf_write_en), 32'(e_we));
    chk("rf_read_en", 32'(rf_read_en), 32'(e_re));
    if (e_we || e_re) chk("rf_address", 32'(rf_address), 32'(e_addr));
    if (e_we) chk("rf_wr_data", 32'(rf_wr_data), 32'(e_wd));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("rsp_data", 32'(rsp_data), (e_rsp != 0) ? 32'(e_rdata) : 32'd0);
    chk("lock_timeout", 32'(lock_timeout), 32'(m_lto));
    s_we = rf_write_en; s_re = rf_read_en; s_addr = rf_address; s_wd = rf_wr_data;
  endtask

  task automatic advance();
    logic       cw;
    logic [5:0] ca;
    logic [7:0] cd;
    @(posedge clock);
    #1;
    if (s_we) rf_mem[s_addr] = s_wd;
    rf_rd_data = s_re ? rf_mem[s_addr] : 8'($urandom);
    e_rsp = p_rsp; e_rdata = p_rdata; p_rsp = '0; p_rdata = '0;
    e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wd = '0;
    if (m_g >= 0) begin
      cw = req_we[m_g];
      ca = req_addr[m_g*6 +: 6];
      cd = req_wdata[m_g*8 +: 8];
      e_we = cw; e_re = !cw; e_addr = ca; e_wd = cw ? cd : 8'h00;
      if (cw) ref_mem[ca] = cd;
      else begin
        p_rsp   = 3'(1 << m_g);
        p_rdata = ref_mem[ca];
      end
      m_ptr  = (m_g + 1) % N;
      m_idle = 0;
      if (!m_locked && req_lock[m_g]) begin
        m_locked = 1'b1;
        m_owner  = m_g;
      end else if (m_locked && !req_lock[m_g]) begin
        m_locked = 1'b0;
      end
    end else if (m_locked) begin
      m_idle++;
      if (m_lto) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
        m_idle   = 0;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  req, we, lk;
    logic [17:0] addr;
    logic [23:0] wd;
    logic [2:0]  e_gnt;
    logic        e_we, e_re;
    logic [5:0]  e_addr;
    logic [7:0]  e_wd;
    logic [2:0]  e_rsp;
    logic [7:0]  e_rdata;
  } tvec_t;

  tvec_t tv [13];

  initial begin
    logic [7:0] v;
    logic [2:0] r, we, lk;

    tv[0]  = '{3'b111, 3'b000, 3'b000, AD_A, W0, 3'b001, 1'b0, 1'b0, 6'h00, 8'h00, 3'b000, 8'h00};
    tv[1]  = '{3'b111, 3'b000, 3'b000, AD_A, W0, 3'b010, 1'b0, 1'b1, 6'h05, 8'h00, 3'b000, 8'h00};
    tv[2]  = '{3'b111, 3'b000, 3'b000, AD_A, W0, 3'b100, 1'b0, 1'b1, 6'h0C, 8'h00, 3'b001, 8'h3F};
    tv[3]  = '{3'b111, 3'b000, 3'b000, AD_A, W0, 3'b001, 1'b0, 1'b1, 6'h0C, 8'h00, 3'b010, 8'h11};
    tv[4]  = '{3'b010, 3'b010, 3'b000, AD_A, W1, 3'b010, 1'b0, 1'b1, 6'h05, 8'h00, 3'b100, 8'h11};
    tv[5]  = '{3'b000, 3'b000, 3'b000, AD_A, W0, 3'b000, 1'b1, 1'b0, 6'h0C, 8'hA5, 3'b001, 8'h3F};
    tv[6]  = '{3'b000, 3'b000, 3'b000, AD_A, W0, 3'b000, 1'b0, 1'b0, 6'h00, 8'h00, 3'b000, 8'h00};
    tv[7]  = '{3'b101, 3'b100, 3'b100, AD_A, W2, 3'b100, 1'b0, 1'b0, 6'h00, 8'h00, 3'b000, 8'h00};
    tv[8]  = '{3'b001, 3'b000, 3'b000, AD_A, W2, 3'b000, 1'b1, 1'b0, 6'h0C, 8'h77, 3'b000, 8'h00};
    tv[9]  = '{3'b101, 3'b100, 3'b000, AD_B, W3, 3'b100, 1'b0, 1'b0, 6'h00, 8'h00, 3'b000, 8'h00};
    tv[10] = '{3'b001, 3'b000, 3'b000, AD_B, W0, 3'b001, 1'b1, 1'b0, 6'h0E, 8'h78, 3'b000, 8'h00};
    tv[11] = '{3'b000, 3'b000, 3'b000, AD_B, W0, 3'b000, 1'b0, 1'b1, 6'h05, 8'h00, 3'b000, 8'h00};
    tv[12] = '{3'b000, 3'b000, 3'b000, AD_B, W0, 3'b000, 1'b0, 1'b0, 6'h00, 8'h00, 3'b001, 8'h3F};

    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      rf_mem[i]  = v;
      ref_mem[i] = v;
    end
    rf_mem[5]  = 8'h3F; ref_mem[5]  = 8'h3F;
    rf_mem[12] = 8'h11; ref_mem[12] = 8'h11;

    model_reset();
    s_we = 1'b0; s_re = 1'b0; s_addr = '0; s_wd = '0;
    reset = 1'b1;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    rf_rd_data = 8'h5A;

    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("reset_rf_read_en", 32'(rf_read_en), 32'd0);
    chk("reset_rf_address", 32'(rf_address), 32'd0);
    chk("reset_rf_wr_data", 32'(rf_wr_data), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_lock_timeout", 32'(lock_timeout), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive_and_check(tv[i].req, tv[i].we, tv[i].lk, tv[i].addr, tv[i].wd);
      chk($sformatf("tv%0d_gnt", i), 32'(gnt), 32'(tv[i].e_gnt));
      chk($sformatf("tv%0d_we", i), 32'(rf_write_en), 32'(tv[i].e_we));
      chk($sformatf("tv%0d_re", i), 32'(rf_read_en), 32'(tv[i].e_re));
      if (tv[i].e_we || tv[i].e_re) chk($sformatf("tv%0d_addr", i), 32'(rf_address), 32'(tv[i].e_addr));
      if (tv[i].e_we) chk($sformatf("tv%0d_wdata", i), 32'(rf_wr_data), 32'(tv[i].e_wd));
      chk($sformatf("tv%0d_rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rsp));
      chk($sformatf("tv%0d_rsp_data", i), 32'(rsp_data), 32'(tv[i].e_rdata));
      advance();
    end

    // Requester 1 takes the lock with requesters 0 and 2 waiting behind it.
    drive_and_check(3'b010, 3'b000, 3'b010, AD_A, W0);
    chk("lock_take_gnt", 32'(gnt), 32'b010);
    advance();
`ifdef REG_ARB_LOCK_TIMEOUT_EN
    for (int i = 1; i <= LT; i++) begin
      drive_and_check(3'b101, 3'b000, 3'b000, AD_A, W0);
      chk("to_wait_gnt", 32'(gnt), 32'd0);
      chk("to_pulse", 32'(lock_timeout), 32'(i == LT));
      advance();
    end
    drive_and_check(3'b101, 3'b000, 3'b000, AD_A, W0);
    chk("to_next_gnt", 32'(gnt), 32'b100);
    chk("to_pulse_done", 32'(lock_timeout), 32'd0);
    advance();
`else
    for (int i = 0; i < 12; i++) begin
      drive_and_check(3'b101, 3'b000, 3'b000, AD_A, W0);
      chk("hold_wait_gnt", 32'(gnt), 32'd0);
      chk("hold_no_pulse", 32'(lock_timeout), 32'd0);
      advance();
    end
    drive_and_check(3'b111, 3'b000, 3'b000, AD_A, W0);
    chk("hold_release_gnt", 32'(gnt), 32'b010);
    advance();
    drive_and_check(3'b101, 3'b000, 3'b000, AD_A, W0);
    chk("hold_after_gnt", 32'(gnt), 32'b100);
    advance();
`endif

    // Reset lands while a read is between grant and response.
    drive_and_check(3'b010, 3'b000, 3'b000, AD_A, W0);
    chk("rst_pre_gnt", 32'(gnt), 32'b010);
    advance();
    @(negedge clock);
    req = '0;
    reset = 1'b1;
    #1;
    chk("rst_rf_read_en", 32'(rf_read_en), 32'd0);
    chk("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_rf_address", 32'(rf_address), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    @(posedge clock);
    #1;
    rf_rd_data = 8'($urandom);
    model_reset();
    s_we = 1'b0; s_re = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_drop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_drop_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clock);
    #1;
    rf_rd_data = 8'($urandom);
    drive_and_check(3'b111, 3'b000, 3'b000, AD_A, W0);
    chk("rst_next_gnt", 32'(gnt), 32'b001);
    advance();

    for (int c = 0; c < 1500; c++) begin
      r  = 3'($urandom);
      we = 3'($urandom);
      lk = 3'($urandom) & 3'($urandom) & 3'($urandom);
      drive_and_check(r, we, lk, 18'($urandom), 24'($urandom));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
